// File: rtl/clk_div_mc_pkg.sv
// Shared types and phase-length helpers for the multi-channel clock divider.
// Contents:
//   ch_state_e  per-channel FSM state (IDLE, LOW, HIGH)
//   div_calc_t  wide working type for phase arithmetic; callers cast in and out
//   low_cnt()   low-phase length for a divisor, ceil(d/2); 1 for bypass divisors
//   high_cnt()  high-phase length for a divisor, floor(d/2); 1 for bypass divisors
package clk_div_mc_pkg;

   localparam int unsigned DIV_CALC_W = 32;

   typedef logic [DIV_CALC_W-1:0] div_calc_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } ch_state_e;

   // Odd divisors give the extra cycle to the low phase.
   function automatic div_calc_t low_cnt(input div_calc_t d);
      div_calc_t r;
      if (d < DIV_CALC_W'(2)) begin
         r = DIV_CALC_W'(1);
      end else begin
         r = d - (d >> 1);
      end
      return r;
   endfunction

   function automatic div_calc_t high_cnt(input div_calc_t d);
      div_calc_t r;
      if (d < DIV_CALC_W'(2)) begin
         r = DIV_CALC_W'(1);
      end else begin
         r = d >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/clk_div_mc_ch.sv
// One divider channel: phase FSM, phase counter, divisor shadow register with
// valid/ready load, and a negedge bypass select that routes clk_i straight
// through for divisors 0 and 1.
// Optional feature: CLK_DIV_MC_SYNC_EN adds sync_i (restart LOW phase).
// Ports:
//   clk_i        source clock
//   arst_i       asynchronous active-high reset
//   en_i         run enable
//   div_i        divisor offered for loading
//   div_valid_i  divisor offer
//   sync_i       phase restart (CLK_DIV_MC_SYNC_EN only)
//   div_ready_o  shadow register empty
//   clk_o        divided (or bypassed) clock
//   busy_o       channel not IDLE
module clk_div_mc_ch
   import clk_div_mc_pkg::*;
#(
   parameter int unsigned DIVISOR_SIZE = 9,
   parameter int unsigned RST_DIVISOR  = 2
) (
   input  logic                    clk_i,
   input  logic                    arst_i,
   input  logic                    en_i,
   input  logic [DIVISOR_SIZE-1:0] div_i,
   input  logic                    div_valid_i,
`ifdef CLK_DIV_MC_SYNC_EN
   input  logic                    sync_i,
`endif
   output logic                    div_ready_o,
   output logic                    clk_o,
   output logic                    busy_o
);

   ch_state_e               state_q, state_d;
   logic [DIVISOR_SIZE-1:0] cnt_q, cnt_d;
   logic [DIVISOR_SIZE-1:0] div_q, div_d;
   logic [DIVISOR_SIZE-1:0] shd_q, shd_d;
   logic                    rdy_q, rdy_d;
   logic                    clk_q;
   logic                    busy_q;
   logic                    byp_q;

   logic [DIVISOR_SIZE-1:0] lo_last;
   logic [DIVISOR_SIZE-1:0] hi_last;
   logic                    low_done;
   logic                    high_done;
   logic                    byp_mode;
   logic                    nxt_byp;
   logic                    sync_hit;
   logic                    bnd;
   logic                    apply;

   // Terminal counts of the active divisor's phases.
   assign lo_last   = DIVISOR_SIZE'(low_cnt(DIV_CALC_W'(div_q)) - DIV_CALC_W'(1));
   assign hi_last   = DIVISOR_SIZE'(high_cnt(DIV_CALC_W'(div_q)) - DIV_CALC_W'(1));
   assign low_done  = (state_q == LOW)  && (cnt_q == lo_last);
   assign high_done = (state_q == HIGH) && (cnt_q == hi_last);
   assign byp_mode  = (div_q < DIVISOR_SIZE'(2));

`ifdef CLK_DIV_MC_SYNC_EN
   // Bypassed channels have no phase to realign.
   assign sync_hit = sync_i && (state_q != IDLE) && !byp_mode;
`else
   assign sync_hit = 1'b0;
`endif

   // End of LOW is the period boundary; IDLE and sync are boundaries as well.
   assign bnd     = (state_q == IDLE) || low_done || sync_hit;
   assign apply   = !rdy_q && bnd;
   assign nxt_byp = apply ? (shd_q < DIVISOR_SIZE'(2)) : byp_mode;

   // Next-state, counter and divisor/shadow bookkeeping.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      shd_d   = shd_q;
      rdy_d   = rdy_q;

      if (rdy_q && div_valid_i) begin
         shd_d = div_i;
         rdy_d = 1'b0;
      end

      if (apply) begin
         div_d = shd_q;
         rdy_d = 1'b1;
      end

      if (sync_hit) begin
         state_d = en_i ? LOW : IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (en_i) begin
                  state_d = LOW;
                  cnt_d   = '0;
               end
            end
            LOW: begin
               if (low_done) begin
                  cnt_d = '0;
                  if (!en_i) begin
                     state_d = IDLE;
                  end else if (byp_mode || nxt_byp) begin
                     // Bypass entry/exit: hold low so the mux switches with both sources low.
                     state_d = LOW;
                  end else begin
                     state_d = HIGH;
                  end
               end else begin
                  cnt_d = cnt_q + DIVISOR_SIZE'(1);
               end
            end
            HIGH: begin
               if (high_done) begin
                  cnt_d   = '0;
                  state_d = en_i ? LOW : IDLE;
               end else begin
                  cnt_d = cnt_q + DIVISOR_SIZE'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         div_q   <= DIVISOR_SIZE'(RST_DIVISOR);
         shd_q   <= '0;
         rdy_q   <= 1'b1;
         clk_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         shd_q   <= shd_d;
         rdy_q   <= rdy_d;
         clk_q   <= (state_d == HIGH);
         busy_q  <= (state_d != IDLE);
      end
   end

   // Bypass select moves on the falling edge while the divided clock is low,
   // so both mux inputs are low at the switch instant.
   always_ff @(negedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         byp_q <= 1'b0;
      end else if (!clk_q && (state_q != HIGH)) begin
         byp_q <= byp_mode && (state_q != IDLE);
      end
   end

   assign clk_o       = byp_q ? clk_i : clk_q;
   assign div_ready_o = rdy_q;
   assign busy_o      = busy_q;

endmodule

// File: rtl/clk_div_mc.sv
// Multi-channel programmable clock divider: NUM_CH independent glitch-free
// divided clocks from clk_i, each with its own divisor load handshake.
// Optional feature: CLK_DIV_MC_SYNC_EN adds sync_i, broadcast to all channels.
// Ports:
//   clk_i        source clock
//   arst_i       asynchronous active-high reset
//   en_i         per-channel run enable
//   div_i        per-channel divisor, [NUM_CH-1:0][DIVISOR_SIZE-1:0]
//   div_valid_i  per-channel divisor offer
//   sync_i       phase restart of all running channels (CLK_DIV_MC_SYNC_EN only)
//   div_ready_o  per-channel shadow register free
//   clk_o        divided clocks
//   busy_o       per-channel running (not IDLE)
module clk_div_mc
   import clk_div_mc_pkg::*;
#(
   parameter int unsigned NUM_CH       = 4,
   parameter int unsigned DIVISOR_SIZE = 9,
   parameter int unsigned RST_DIVISOR  = 2
) (
   input  logic                                 clk_i,
   input  logic                                 arst_i,
   input  logic [NUM_CH-1:0]                    en_i,
   input  logic [NUM_CH-1:0][DIVISOR_SIZE-1:0]  div_i,
   input  logic [NUM_CH-1:0]                    div_valid_i,
`ifdef CLK_DIV_MC_SYNC_EN
   input  logic                                 sync_i,
`endif
   output logic [NUM_CH-1:0]                    div_ready_o,
   output logic [NUM_CH-1:0]                    clk_o,
   output logic [NUM_CH-1:0]                    busy_o
);

   // One independent channel per output.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clk_div_mc_ch #(
         .DIVISOR_SIZE (DIVISOR_SIZE),
         .RST_DIVISOR  (RST_DIVISOR)
      ) u_ch (
         .clk_i       (clk_i),
         .arst_i      (arst_i),
         .en_i        (en_i[g]),
         .div_i       (div_i[g]),
         .div_valid_i (div_valid_i[g]),
`ifdef CLK_DIV_MC_SYNC_EN
         .sync_i      (sync_i),
`endif
         .div_ready_o (div_ready_o[g]),
         .clk_o       (clk_o[g]),
         .busy_o      (busy_o[g])
      );
   end

endmodule

// File: tb/tb_clk_div_mc.sv
module tb_clk_div_mc;

   logic            clk;
   logic            arst;
   logic [3:0]      en;
   logic [3:0][8:0] div;
   logic [3:0]      dv;
   logic [3:0]      rdy;
   logic [3:0]      clk_o;
   logic [3:0]      busy;
`ifdef CLK_DIV_MC_SYNC_EN
   logic            sync;
`endif

   int total = 0;
   int bad   = 0;

   logic    gl_en   = 1'b0;
   int      glitches = 0;
   realtime last_t  = 0.0;

   clk_div_mc #(
      .NUM_CH       (4),
      .DIVISOR_SIZE (9),
      .RST_DIVISOR  (2)
   ) dut (
      .clk_i       (clk),
      .arst_i      (arst),
      .en_i        (en),
      .div_i       (div),
      .div_valid_i (dv),
`ifdef CLK_DIV_MC_SYNC_EN
      .sync_i      (sync),
`endif
      .div_ready_o (rdy),
      .clk_o       (clk_o),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Any clk_o[2] level shorter than half a source period is a glitch.
   always @(posedge clk_o[2] or negedge clk_o[2]) begin
      if (gl_en && (($realtime - last_t) < 5.0)) glitches++;
      last_t = $realtime;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not reach summary");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      arst = 1'b1;
      en   = '0;
      div  = '0;
      dv   = '0;
`ifdef CLK_DIV_MC_SYNC_EN
      sync = 1'b0;
`endif
      #1;
      tick;
      tick;
      total++;
      if (clk_o !== 4'h0) begin bad++; $display("FAIL reset_clk got=%h want=0", clk_o); end
      total++;
      if (busy !== 4'h0) begin bad++; $display("FAIL reset_busy got=%h want=0", busy); end
      total++;
      if (rdy !== 4'hF) begin bad++; $display("FAIL reset_ready got=%h want=f", rdy); end
      arst = 1'b0;
   endtask

   task automatic test_default_div;
      en[0] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick;
         total++;
         if (clk_o[0] !== 1'((i % 2) == 1)) begin
            bad++;
            $display("FAIL default_div cyc=%0d got=%b want=%b", i, clk_o[0], (i % 2) == 1);
         end
      end
      total++;
      if (busy[0] !== 1'b1) begin bad++; $display("FAIL default_busy got=%b want=1", busy[0]); end
   endtask

   task automatic test_load_while_running;
      logic [12:0] exp_clk;
      exp_clk = 13'b1000110001100;
      div[1] = 9'd4;
      dv[1]  = 1'b1;
      tick;
      total++;
      if (rdy[1] !== 1'b0) begin bad++; $display("FAIL load_idle_ready0 got=%b want=0", rdy[1]); end
      dv[1] = 1'b0;
      tick;
      total++;
      if (rdy[1] !== 1'b1) begin bad++; $display("FAIL load_idle_ready1 got=%b want=1", rdy[1]); end
      en[1] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         total++;
         if (clk_o[1] !== 1'(i >= 2)) begin
            bad++;
            $display("FAIL d4_start cyc=%0d got=%b want=%b", i, clk_o[1], i >= 2);
         end
      end
      div[1] = 9'd5;
      dv[1]  = 1'b1;
      for (int i = 0; i < 13; i++) begin
         tick;
         if (i == 0) begin
            // Offer while ready is low must be ignored.
            div[1] = 9'd9;
            dv[1]  = 1'b1;
         end else if (i == 1) begin
            dv[1] = 1'b0;
         end
         total++;
         if (clk_o[1] !== exp_clk[i]) begin
            bad++;
            $display("FAIL d4_to_d5 cyc=%0d got=%b want=%b", i, clk_o[1], exp_clk[i]);
         end
         if (i < 4) begin
            total++;
            if (rdy[1] !== 1'(i >= 2)) begin
               bad++;
               $display("FAIL d5_ready cyc=%0d got=%b want=%b", i, rdy[1], i >= 2);
            end
         end
      end
   endtask

   task automatic test_bypass;
      logic [10:0] exp_clk;
      exp_clk = 11'b10001110011;
      gl_en   = 1'b1;
      en[2]   = 1'b1;
      div[2]  = 9'd1;
      dv[2]   = 1'b1;
      tick;
      dv[2] = 1'b0;
      repeat (4) tick;
      for (int i = 0; i < 3; i++) begin
         tick;
         total++;
         if (clk_o[2] !== 1'b1) begin bad++; $display("FAIL bypass_hi cyc=%0d got=%b want=1", i, clk_o[2]); end
         @(negedge clk);
         #1;
         total++;
         if (clk_o[2] !== 1'b0) begin bad++; $display("FAIL bypass_lo cyc=%0d got=%b want=0", i, clk_o[2]); end
      end
      tick;
      total++;
      if (rdy[2] !== 1'b1) begin bad++; $display("FAIL bypass_ready got=%b want=1", rdy[2]); end
      div[2] = 9'd6;
      dv[2]  = 1'b1;
      for (int i = 0; i < 11; i++) begin
         tick;
         if (i == 0) dv[2] = 1'b0;
         total++;
         if (clk_o[2] !== exp_clk[i]) begin
            bad++;
            $display("FAIL bypass_exit cyc=%0d got=%b want=%b", i, clk_o[2], exp_clk[i]);
         end
         if (i < 2) begin
            total++;
            if (rdy[2] !== 1'(i == 1)) begin
               bad++;
               $display("FAIL bypass_exit_ready cyc=%0d got=%b want=%b", i, rdy[2], i == 1);
            end
         end
      end
      gl_en = 1'b0;
      total++;
      if (glitches !== 0) begin bad++; $display("FAIL bypass_glitch got=%0d want=0", glitches); end
   endtask

   task automatic test_disable_high;
      div[3] = 9'd8;
      dv[3]  = 1'b1;
      tick;
      dv[3] = 1'b0;
      tick;
      en[3] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick;
         total++;
         if (clk_o[3] !== 1'(i >= 4)) begin
            bad++;
            $display("FAIL d8_start cyc=%0d got=%b want=%b", i, clk_o[3], i >= 4);
         end
      end
      en[3] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         total++;
         if (clk_o[3] !== 1'(i < 2)) begin
            bad++;
            $display("FAIL d8_drop cyc=%0d got=%b want=%b", i, clk_o[3], i < 2);
         end
      end
      total++;
      if (busy[3] !== 1'b0) begin bad++; $display("FAIL d8_idle_busy got=%b want=0", busy[3]); end
      en[3] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick;
         total++;
         if (clk_o[3] !== 1'(i == 4)) begin
            bad++;
            $display("FAIL d8_reenable cyc=%0d got=%b want=%b", i, clk_o[3], i == 4);
         end
      end
      total++;
      if (busy[3] !== 1'b1) begin bad++; $display("FAIL d8_reenable_busy got=%b want=1", busy[3]); end
   endtask

   task automatic test_reset_mid;
      bit seen;
      seen   = 1'b0;
      div[3] = 9'd10;
      dv[3]  = 1'b1;
      tick;
      dv[3] = 1'b0;
      total++;
      if (rdy[3] !== 1'b0) begin bad++; $display("FAIL rst_pending_ready got=%b want=0", rdy[3]); end
      for (int i = 0; i < 20; i++) begin
         if (clk_o[3] === 1'b1) begin
            seen = 1'b1;
            break;
         end
         tick;
      end
      total++;
      if (!seen) begin bad++; $display("FAIL rst_wait_high got=%b want=1", clk_o[3]); end
      #1;
      arst = 1'b1;
      #1;
      total++;
      if (clk_o !== 4'h0) begin bad++; $display("FAIL rst_mid_clk got=%h want=0", clk_o); end
      total++;
      if (busy !== 4'h0) begin bad++; $display("FAIL rst_mid_busy got=%h want=0", busy); end
      total++;
      if (rdy !== 4'hF) begin bad++; $display("FAIL rst_mid_ready got=%h want=f", rdy); end
      tick;
      tick;
      arst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick;
         total++;
         if (clk_o[3] !== 1'((i % 2) == 1)) begin
            bad++;
            $display("FAIL rst_div_restored cyc=%0d got=%b want=%b", i, clk_o[3], (i % 2) == 1);
         end
      end
   endtask

`ifdef CLK_DIV_MC_SYNC_EN
   task automatic test_sync;
      logic [9:0] exp_clk;
      exp_clk = 10'b1000111000;
      en[1]   = 1'b0;
      repeat (6) tick;
      div[0] = 9'd6;
      div[1] = 9'd6;
      dv[0]  = 1'b1;
      dv[1]  = 1'b1;
      tick;
      dv = '0;
      tick;
      tick;
      en[1] = 1'b1;
      repeat (20) tick;
      sync = 1'b1;
      tick;
      sync = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) tick;
         total++;
         if (clk_o[0] !== exp_clk[i]) begin
            bad++;
            $display("FAIL sync_ch0 cyc=%0d got=%b want=%b", i, clk_o[0], exp_clk[i]);
         end
         total++;
         if (clk_o[1] !== exp_clk[i]) begin
            bad++;
            $display("FAIL sync_ch1 cyc=%0d got=%b want=%b", i, clk_o[1], exp_clk[i]);
         end
      end
   endtask
`endif

   initial begin
      test_reset;
      test_default_div;
      test_load_while_running;
      test_bypass;
      test_disable_high;
      test_reset_mid;
`ifdef CLK_DIV_MC_SYNC_EN
      test_sync;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
